// File: rtl/cla_seq_pkg.sv
// Shared types and helpers for the CLA nibble sequencer.
// The state encoding, the nibble width and the nibble count helper live here.
package cla_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of adder nibbles needed to cover an operand of the given width.
  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/cla_seq_lat_cnt.sv
// Loadable down-counter with a zero flag.
// The sequencer uses it to wait out the adder pipeline for each nibble.
// A load takes priority over counting; the count stops at zero.
module cla_seq_lat_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // Load or count down, saturating at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/cla_nibble_sequencer.sv
// Controller for a registered 4-bit carry-lookahead adder stage.
// Operands are accepted whole, fed to the adder one nibble at a time (LSB
// first) with the carry chained between nibbles, and the assembled sum is
// presented downstream.
// Optional: define CLA_SEQ_OVF_EN to add a registered signed-overflow
// output (ovf).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is high only in IDLE; out_valid stays high with sum/cout
// held stable until the edge where out_ready is seen, and never drops
// without that transfer (except by reset).
module cla_nibble_sequencer
  import cla_seq_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ADDER_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic [3:0]       a_in,
  output logic [3:0]       b_in,
  output logic             c_in,
  input  logic [3:0]       s_out,
  input  logic             c_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef CLA_SEQ_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       state_dbg
);

  localparam int NIB   = nib_count(WIDTH);
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int CNT_W = (ADDER_LAT > 0) ? $clog2(ADDER_LAT + 1) : 1;

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
    $error("cla_nibble_sequencer: WIDTH must be a positive multiple of 4");
  end

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [WIDTH-1:0]   op_a_q;
  logic [WIDTH-1:0]   op_b_q;
  logic               cnt_zero;
  logic               accept;
  logic               capture;
  logic               last_nib;
  logic               release_out;
  logic               cnt_load;

  assign accept      = (state == IDLE) && in_valid;
  assign capture     = (state == RUN) && cnt_zero;
  assign last_nib    = (idx == IDX_W'(NIB - 1));
  assign release_out = (state == DONE) && out_ready;
  assign cnt_load    = accept || (capture && !last_nib);

  cla_seq_lat_cnt #(
    .W (CNT_W)
  ) u_lat_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (CNT_W'(ADDER_LAT)),
    .zero     (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: accept -> run each nibble -> hold result until taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)             state_nxt = RUN;
      RUN:     if (cnt_zero && last_nib) state_nxt = DONE;
      DONE:    if (out_ready)            state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs; in_ready reads 1 during reset because state is IDLE.
  always_comb begin
    in_ready  = (state == IDLE);
    state_dbg = state;
  end

  // Operand latch, nibble drive, result capture and output valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_a_q    <= '0;
      op_b_q    <= '0;
      a_in      <= '0;
      b_in      <= '0;
      c_in      <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      if (accept) begin
        op_a_q <= op_a;
        op_b_q <= op_b;
        a_in   <= op_a[NIBBLE_W-1:0];
        b_in   <= op_b[NIBBLE_W-1:0];
        c_in   <= op_cin;
        idx    <= '0;
      end
      if (capture) begin
        sum[NIBBLE_W*int'(idx) +: NIBBLE_W] <= s_out;
        if (!last_nib) begin
          // Next nibble goes out on the same edge, carrying the adder's c_out.
          a_in <= op_a_q[NIBBLE_W*(int'(idx) + 1) +: NIBBLE_W];
          b_in <= op_b_q[NIBBLE_W*(int'(idx) + 1) +: NIBBLE_W];
          c_in <= c_out;
          idx  <= idx + IDX_W'(1);
        end else begin
          cout      <= c_out;
          out_valid <= 1'b1;
`ifdef CLA_SEQ_OVF_EN
          // The top nibble is being captured now, so its MSB is s_out[3].
          ovf <= (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &&
                 (s_out[NIBBLE_W-1] != op_a_q[WIDTH-1]);
`endif
        end
      end
      if (release_out) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Bench for cla_nibble_sequencer with a cycle-accurate 2-deep adder model.
// Expected results come from plain integer addition of the operands.
module tb_cla_nibble_sequencer;

  localparam int WIDTH     = 16;
  localparam int ADDER_LAT = 2;
  localparam int NIB       = WIDTH / 4;
  localparam int PER       = ADDER_LAT + 1;
  localparam int LAT       = NIB * PER;
  localparam int EW        = WIDTH + 2;   // {ovf, cout, sum}

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic             op_cin = 1'b0;
  logic [3:0]       a_in;
  logic [3:0]       b_in;
  logic             c_in;
  logic [3:0]       s_out;
  logic             c_out;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [1:0]       state_dbg;
`ifdef CLA_SEQ_OVF_EN
  logic             ovf;
`endif

  // Registered adder stage: ADDER_LAT = 2 register stages.
  logic [4:0] add_p1 = '0;
  logic [4:0] add_p2 = '0;
  always @(posedge clk) begin
    add_p1 <= 5'({1'b0, a_in} + {1'b0, b_in} + {4'b0, c_in});
    add_p2 <= add_p1;
  end
  assign s_out = add_p2[3:0];
  assign c_out = add_p2[4];

  cla_nibble_sequencer #(
    .WIDTH     (WIDTH),
    .ADDER_LAT (ADDER_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_cin    (op_cin),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
    .s_out     (s_out),
    .c_out     (c_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef CLA_SEQ_OVF_EN
    .ovf       (ovf),
`endif
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} from integer addition.
  function automatic logic [EW-1:0] ref_result(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic cin);
    logic [WIDTH:0] full;
    logic           v;
    full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    v    = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    return {v, full};
  endfunction

  // Carry entering nibble j of a + b + cin.
  function automatic logic carry_into(input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b,
                                      input logic cin, input int j);
    logic [WIDTH:0] m;
    logic [WIDTH:0] t;
    m = ({{WIDTH{1'b0}}, 1'b1} << (4 * j)) - 1'b1;
    t = ({1'b0, a} & m) + ({1'b0, b} & m) + {{WIDTH{1'b0}}, cin};
    return t[4 * j];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
    int k;
    k = 0;
    while (!in_ready && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("in_ready_before_op", 32'(in_ready), 32'd1);
    op_a     = a;
    op_b     = b;
    op_cin   = cin;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    exp_q.push_back(ref_result(a, b, cin));
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input int hold, input bit change_a);
    logic [EW-1:0] e;
    int  k;
    bit  seen;
    start_op(a, b, cin);
    seen = 0;
    for (k = 0; k < LAT + 20; k++) begin
      if (out_valid) begin
        seen = 1;
        break;
      end
      if (k < LAT) begin
        check("a_in_nibble", 32'(a_in), 32'((a >> (4 * (k / PER))) & 16'hF));
        check("b_in_nibble", 32'(b_in), 32'((b >> (4 * (k / PER))) & 16'hF));
        check("c_in_chain",  32'(c_in), 32'(carry_into(a, b, cin, k / PER)));
      end
      if (change_a && k == 0) op_a = 16'hAAAA;
      @(negedge clk);
    end
    check("out_valid_latency", seen ? 32'(k) : 32'hFFFF_FFFF, 32'(LAT));
    if (!seen) begin
      exp_q.delete();
      return;
    end
    for (int h = 0; h < hold; h++) begin
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready",  32'(in_ready), 32'd0);
      check("hold_sum",       32'(sum), 32'(exp_q[0][WIDTH-1:0]));
      in_valid = 1'($urandom_range(0, 1));
      op_a     = WIDTH'($urandom);
      op_b     = WIDTH'($urandom);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    e = exp_q.pop_front();
    check("sum",  32'(sum), 32'(e[WIDTH-1:0]));
    check("cout", 32'(cout), 32'(e[WIDTH]));
`ifdef CLA_SEQ_OVF_EN
    check("ovf",  32'(ovf), 32'(e[WIDTH+1]));
`endif
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop",  32'(out_valid), 32'd0);
    check("in_ready_return", 32'(in_ready), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1;
    check("rst_in_ready",  32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_a_in",      32'(a_in), 32'd0);
    check("rst_c_in",      32'(c_in), 32'd0);
    check("rst_sum",       32'(sum), 32'd0);
    check("rst_cout",      32'(cout), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1, 1'b0);
    run_op(16'h0FFF, 16'h0000, 1'b1, 0, 1'b1);
    run_op(16'h00FF, 16'h0001, 1'b0, 5, 1'b0);

    // Reset in the middle of an operation.
    start_op(16'h8888, 16'h8888, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_a_in",      32'(a_in), 32'd0);
    check("mid_rst_b_in",      32'(b_in), 32'd0);
    check("mid_rst_c_in",      32'(c_in), 32'd0);
    check("mid_rst_sum",       32'(sum), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready",  32'(in_ready), 32'd1);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      check("no_partial_result", 32'(out_valid), 32'd0);
    end
    run_op(16'h0001, 16'h0002, 1'b0, 0, 1'b0);

`ifdef CLA_SEQ_OVF_EN
    run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0, 0, 1'b0);
`endif

    for (int i = 0; i < 12; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), 1'b0);
    end

    // ---------------- final report ----------------
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
